// File: rtl/sram_test_pkg.sv
// Shared types and constants for the SRAM fill/verify sequencer.
// The LFSR pattern mode is built only when SRAM_TEST_LFSR_EN is defined.
package sram_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT,
        FIN
    } state_e;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_INC   = 2'd1;
    localparam logic [1:0] MODE_ADDR  = 2'd2;
    localparam logic [1:0] MODE_LFSR  = 2'd3;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3)
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    // An all-zero LFSR would lock up, so a zero seed loads this instead
    localparam logic [7:0] LFSR_ZERO_SUB = 8'h01;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sram_test_seq_if.sv
// Request/response port between the test sequencer and the byte-wide SRAM controller.
interface sram_test_seq_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              mem;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_f2s;
    logic              ready;
    logic [DATA_W-1:0] data_s2f_r;

    modport master (
        output mem, rw, addr, data_f2s,
        input  ready, data_s2f_r
    );

    modport slave (
        input  mem, rw, addr, data_f2s,
        output ready, data_s2f_r
    );
endinterface

// File: rtl/sram_test_patgen.sv
// Pattern generator for the SRAM test sequencer: maps (mode, seed, index, address) to a data byte.
// With SRAM_TEST_LFSR_EN defined, mode 3 emits an LFSR sequence; otherwise mode 3 is the constant seed.
module sram_test_patgen
    import sram_test_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [7:0]        idx,
    input  logic [7:0]        addr_lo,
    input  logic              load,
    input  logic              step,
    output logic [DATA_W-1:0] pat
);

`ifdef SRAM_TEST_LFSR_EN
    logic [7:0] lfsr;

    // LFSR reloads at the start of each phase so reads replay the write sequence
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= LFSR_ZERO_SUB;
        end else if (load) begin
            lfsr <= (seed[7:0] == 8'h00) ? LFSR_ZERO_SUB : seed[7:0];
        end else if (step) begin
            lfsr <= lfsr_next(lfsr);
        end
    end
`else
    logic unused_lfsr_ports;
    assign unused_lfsr_ports = &{1'b0, clk, reset_n, load, step};
`endif

    // Pattern select
    always_comb begin
        pat = seed;
        case (mode)
            MODE_INC:  pat = seed + DATA_W'(idx);
            MODE_ADDR: pat = DATA_W'(addr_lo) ^ seed;
`ifdef SRAM_TEST_LFSR_EN
            MODE_LFSR: pat = DATA_W'(lfsr);
`endif
            default:   pat = seed;
        endcase
    end

endmodule

// File: rtl/sram_test_seq.sv
// SRAM fill/verify sequencer: on start, writes len pattern bytes from base_addr through the
// controller, reads them back, compares, and reports pass/err_cnt/first_err_addr.
// Optional LFSR pattern mode: define SRAM_TEST_LFSR_EN.
module sram_test_seq
    import sram_test_pkg::*;
#(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    len,
    input  logic [1:0]           mode,
    input  logic [DATA_W-1:0]    seed,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ADDR_W-1:0]    first_err_addr,
    sram_test_seq_if.master      bus
);

    state_e            state, state_nx;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] seed_q;
    logic              guard;

    logic              accept;
    logic              wr_adv;
    logic              rd_cmp;
    logic              last;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] pat;
    logic [DATA_W-1:0] pg_seed;
    logic              pg_load;
    logic              pg_step;

    logic              mem_o;
    logic              rw_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] data_o;

    assign last     = (idx == len_q - ADDR_W'(1));
    assign cur_addr = base_q + idx;   // wraps modulo 2^ADDR_W
    // Raw seed at the accepting edge (latched copy not yet valid), latched copy afterwards
    assign pg_seed  = (state == IDLE) ? seed : seed_q;

    sram_test_patgen #(.DATA_W(DATA_W)) u_patgen (
        .clk     (clk),
        .reset_n (reset_n),
        .mode    (mode_q),
        .seed    (pg_seed),
        .idx     (idx[7:0]),
        .addr_lo (cur_addr[7:0]),
        .load    (pg_load),
        .step    (pg_step),
        .pat     (pat)
    );

    // State register; reset forces IDLE so mem drops immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state, request port drive and per-element control strobes
    always_comb begin
        state_nx = state;
        mem_o    = 1'b0;
        rw_o     = 1'b1;
        addr_o   = '0;
        data_o   = '0;
        accept   = 1'b0;
        wr_adv   = 1'b0;
        rd_cmp   = 1'b0;
        pg_load  = 1'b0;
        pg_step  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    pg_load  = 1'b1;
                    state_nx = (len == '0) ? FIN : WR_REQ;
                end
            end
            WR_REQ: begin
                mem_o  = 1'b1;
                rw_o   = 1'b0;
                addr_o = cur_addr;
                data_o = pat;
                if (bus.ready) state_nx = WR_WAIT;
            end
            WR_WAIT: begin
                if (!guard && bus.ready) begin
                    wr_adv = 1'b1;
                    if (last) begin
                        pg_load  = 1'b1;   // replay the same sequence for readback
                        state_nx = RD_REQ;
                    end else begin
                        pg_step  = 1'b1;
                        state_nx = WR_REQ;
                    end
                end
            end
            RD_REQ: begin
                mem_o  = 1'b1;
                rw_o   = 1'b1;
                addr_o = cur_addr;
                if (bus.ready) state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                if (!guard && bus.ready) begin
                    rd_cmp = 1'b1;
                    if (last) begin
                        state_nx = FIN;
                    end else begin
                        pg_step  = 1'b1;
                        state_nx = RD_REQ;
                    end
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.mem      = mem_o;
    assign bus.rw       = rw_o;
    assign bus.addr     = addr_o;
    assign bus.data_f2s = data_o;

    // Latched pass parameters, element index and the post-request guard flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx    <= '0;
            base_q <= '0;
            len_q  <= '0;
            mode_q <= '0;
            seed_q <= '0;
            guard  <= 1'b0;
        end else begin
            // Controller is still leaving idle on the cycle after an accepted request
            guard <= (state == WR_REQ || state == RD_REQ) && bus.ready;
            if (accept) begin
                base_q <= base_addr;
                len_q  <= len;
                mode_q <= mode;
                seed_q <= seed;
                idx    <= '0;
            end else if (wr_adv) begin
                idx <= last ? '0 : idx + ADDR_W'(1);
            end else if (rd_cmp && !last) begin
                idx <= idx + ADDR_W'(1);
            end
        end
    end

    // Compare, saturating error count, first-error capture and pass/done/busy reporting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b0;
        end else begin
            done <= (state == FIN);
            busy <= (state_nx != IDLE);
            if (accept) begin
                err_cnt        <= '0;
                first_err_addr <= '0;
                pass           <= 1'b0;
            end else if (rd_cmp && (bus.data_s2f_r != pat)) begin
                if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
                if (err_cnt == '0) first_err_addr <= cur_addr;
            end
            if (state == FIN) pass <= (err_cnt == '0);
        end
    end

endmodule

// File: tb/tb_sram_test_seq.sv
// Directed bench for sram_test_seq with a behavioural 3-cycle SRAM controller and byte array.
// Honors SRAM_TEST_LFSR_EN for the mode-3 expectations.
module tb_sram_test_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [18:0] base_addr = '0;
    logic [18:0] len = '0;
    logic [1:0]  mode = '0;
    logic [7:0]  seed = '0;
    logic        busy, done, pass;
    logic [15:0] err_cnt;
    logic [18:0] first_err_addr;

    sram_test_seq_if #(.ADDR_W(19), .DATA_W(8)) bus ();

    sram_test_seq #(.ADDR_W(19), .DATA_W(8), .ERR_CNT_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .len            (len),
        .mode           (mode),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // Controller model: idle -> s1 -> s2 -> idle, ready only in idle, registered read data
    logic [7:0]  sram [0:524287];
    int          cst;
    logic [18:0] c_addr;
    logic        c_rw;
    logic [7:0]  c_data;
    logic [7:0]  rdata;
    logic        stuck_en = 1'b0;
    logic [18:0] stuck_addr = 19'h00102;
    logic [18:0] wr_a[$];
    logic [7:0]  wr_d[$];
    int          acc_cnt = 0;

    assign bus.ready      = (cst == 0);
    assign bus.data_s2f_r = rdata;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cst   <= 0;
            rdata <= 8'h00;
        end else begin
            case (cst)
                0: if (bus.mem) begin
                    c_addr  <= bus.addr;
                    c_rw    <= bus.rw;
                    c_data  <= bus.data_f2s;
                    cst     <= 1;
                    acc_cnt <= acc_cnt + 1;
                    if (!bus.rw) begin
                        wr_a.push_back(bus.addr);
                        wr_d.push_back(bus.data_f2s);
                    end
                end
                1: cst <= 2;
                default: begin
                    if (c_rw) rdata <= sram[c_addr] | ((stuck_en && c_addr == stuck_addr) ? 8'h01 : 8'h00);
                    else      sram[c_addr] <= c_data;
                    cst <= 0;
                end
            endcase
        end
    end

    int total = 0;
    int bad = 0;
    int run_cyc;
    bit run_to;

    // Start a pass and count cycles until done; optionally pulse start again mid-pass
    task automatic run_pass(input logic [18:0] b, input logic [18:0] l, input logic [1:0] m,
                            input logic [7:0] s, input int inj_at);
        int limit;
        limit = int'(l) * 8 + 20;
        @(negedge clk);
        base_addr = b; len = l; mode = m; seed = s; start = 1'b1;
        run_cyc = 0; run_to = 1'b1;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            run_cyc++;
            if (run_cyc == inj_at) begin
                start = 1'b1; base_addr = 19'h00200; len = 19'd1; seed = 8'h55; mode = 2'd0;
            end
            if (done) begin
                run_to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL reset_pass: got %b want 0", pass); end
        total++; if (err_cnt !== 16'h0) begin bad++; $display("FAIL reset_err_cnt: got %0h want 0", err_cnt); end
        total++; if (first_err_addr !== 19'h0) begin bad++; $display("FAIL reset_first_err: got %0h want 0", first_err_addr); end
        total++; if (bus.mem !== 1'b0) begin bad++; $display("FAIL reset_mem: got %b want 0", bus.mem); end
        total++; if (bus.rw !== 1'b1) begin bad++; $display("FAIL reset_rw: got %b want 1", bus.rw); end
        total++; if (bus.addr !== 19'h0) begin bad++; $display("FAIL reset_addr: got %0h want 0", bus.addr); end
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || bus.mem !== 1'b0) begin bad++; $display("FAIL idle_quiet: busy=%b mem=%b want 0 0", busy, bus.mem); end
    endtask

    task automatic test_inc(input int inj_at);
        int w0, a0;
        w0 = wr_a.size(); a0 = acc_cnt;
        run_pass(19'h00010, 19'd4, 2'd1, 8'h20, inj_at);
        total++; if (run_cyc !== 34) begin bad++; $display("FAIL inc_cycles(inj=%0d): got %0d want 34", inj_at, run_cyc); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL inc_pass: got %b want 1", pass); end
        total++; if (err_cnt !== 16'h0) begin bad++; $display("FAIL inc_err_cnt: got %0h want 0", err_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL inc_busy_at_done: got %b want 0", busy); end
        total++; if (acc_cnt - a0 !== 8) begin bad++; $display("FAIL inc_req_count: got %0d want 8", acc_cnt - a0); end
        total++;
        if (wr_a.size() - w0 !== 4) begin
            bad++; $display("FAIL inc_write_count: got %0d want 4", wr_a.size() - w0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (wr_a[w0+k] !== 19'h00010 + 19'(k) || wr_d[w0+k] !== 8'h20 + 8'(k)) begin
                    bad++; $display("FAIL inc_write%0d: got %0h/%0h want %0h/%0h", k, wr_a[w0+k], wr_d[w0+k],
                                    19'h00010 + 19'(k), 8'h20 + 8'(k));
                end
            end
        end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL inc_done_width: got %b want 0", done); end
    endtask

    task automatic test_wrap();
        int w0;
        logic [18:0] ea [4];
        logic [7:0]  ed [4];
        ea[0] = 19'h7FFFE; ea[1] = 19'h7FFFF; ea[2] = 19'h00000; ea[3] = 19'h00001;
        ed[0] = 8'hFE; ed[1] = 8'hFF; ed[2] = 8'h00; ed[3] = 8'h01;
        w0 = wr_a.size();
        run_pass(19'h7FFFE, 19'd4, 2'd2, 8'h00, 0);
        total++; if (pass !== 1'b1 || run_cyc !== 34) begin bad++; $display("FAIL wrap_pass: got pass=%b cyc=%0d want 1 34", pass, run_cyc); end
        total++;
        if (wr_a.size() - w0 !== 4) begin
            bad++; $display("FAIL wrap_write_count: got %0d want 4", wr_a.size() - w0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (wr_a[w0+k] !== ea[k] || wr_d[w0+k] !== ed[k]) begin
                    bad++; $display("FAIL wrap_write%0d: got %0h/%0h want %0h/%0h", k, wr_a[w0+k], wr_d[w0+k], ea[k], ed[k]);
                end
            end
        end
    endtask

    task automatic test_stuck();
        stuck_en = 1'b1;
        run_pass(19'h00100, 19'd8, 2'd0, 8'hAA, 0);
        stuck_en = 1'b0;
        total++; if (run_cyc !== 66) begin bad++; $display("FAIL stuck_cycles: got %0d want 66", run_cyc); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL stuck_pass: got %b want 0", pass); end
        total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL stuck_err_cnt: got %0d want 1", err_cnt); end
        total++; if (first_err_addr !== 19'h00102) begin bad++; $display("FAIL stuck_first_err: got %0h want 102", first_err_addr); end
    endtask

    task automatic test_empty();
        int a0;
        a0 = acc_cnt;
        run_pass(19'h00300, 19'd0, 2'd0, 8'h11, 0);
        total++; if (run_cyc !== 2) begin bad++; $display("FAIL empty_cycles: got %0d want 2", run_cyc); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL empty_pass: got %b want 1", pass); end
        total++; if (err_cnt !== 16'h0 || first_err_addr !== 19'h0) begin bad++; $display("FAIL empty_stats_cleared: got %0h/%0h want 0/0", err_cnt, first_err_addr); end
        total++; if (acc_cnt !== a0) begin bad++; $display("FAIL empty_no_mem: got %0d requests want 0", acc_cnt - a0); end
    endtask

    task automatic test_lfsr();
        int w0;
        logic [7:0] ed [6];
`ifdef SRAM_TEST_LFSR_EN
        ed[0] = 8'h01; ed[1] = 8'h02; ed[2] = 8'h04; ed[3] = 8'h08; ed[4] = 8'h11; ed[5] = 8'h23;
`else
        for (int k = 0; k < 6; k++) ed[k] = 8'h00;
`endif
        w0 = wr_a.size();
        run_pass(19'h00400, 19'd6, 2'd3, 8'h00, 0);
        total++; if (pass !== 1'b1 || run_cyc !== 50) begin bad++; $display("FAIL lfsr_pass: got pass=%b cyc=%0d want 1 50", pass, run_cyc); end
        total++;
        if (wr_a.size() - w0 !== 6) begin
            bad++; $display("FAIL lfsr_write_count: got %0d want 6", wr_a.size() - w0);
        end else begin
            for (int k = 0; k < 6; k++) begin
                total++;
                if (wr_d[w0+k] !== ed[k]) begin
                    bad++; $display("FAIL lfsr_byte%0d: got %0h want %0h", k, wr_d[w0+k], ed[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        stuck_en = 1'b1;
        @(negedge clk);
        base_addr = 19'h00102; len = 19'd4; mode = 2'd0; seed = 8'hAA; start = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.mem && bus.rw && bus.addr == 19'h00103) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found) begin bad++; $display("FAIL rstmid_reach_read: got no read of 103 want one"); end
        if (found) begin
            @(posedge clk);
            @(negedge clk);
            total++; if (err_cnt !== 16'd1 || busy !== 1'b1) begin bad++; $display("FAIL rstmid_before: got err=%0d busy=%b want 1 1", err_cnt, busy); end
            #2 reset_n = 1'b0;
            #1;
            total++; if (bus.mem !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_async: got mem=%b busy=%b want 0 0", bus.mem, busy); end
            total++; if (err_cnt !== 16'h0 || done !== 1'b0 || bus.rw !== 1'b1) begin bad++; $display("FAIL rstmid_state: got err=%0d done=%b rw=%b want 0 0 1", err_cnt, done, bus.rw); end
            @(negedge clk);
            reset_n = 1'b1;
        end
        stuck_en = 1'b0;
        run_pass(19'h00102, 19'd4, 2'd0, 8'hAA, 0);
        total++; if (pass !== 1'b1 || err_cnt !== 16'h0 || run_cyc !== 34) begin bad++; $display("FAIL rstmid_rerun: got pass=%b err=%0d cyc=%0d want 1 0 34", pass, err_cnt, run_cyc); end
    endtask

    initial begin
        test_reset();
        test_inc(0);
        test_wrap();
        test_stuck();
        test_empty();
        test_inc(10);
        test_lfsr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
